tiny5_csr_counters: RTL and testbench

CSR responder for the tiny5 pipeline. It holds the user-level read-only counters `cycle`, `time` and `instret`, plus their high halves. It answers the decode-stage CSR read with the selected 32-bit half and accepts CSR writes from writeback. Writes to read-only counters are flagged as illegal and have no effect.

---
 rtl/tiny5_csr_counters.sv | 97 +++++++++
 tb/tb_tiny5_csr_counters.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny5_csr_counters.sv
// tiny5 user counters (cycle/time/instret): 0-cycle combinational read, writes land on the next edge, no backpressure.
// Define TINY5_CSR_COUNTER_WR_EN to make cycle/instret writable; time is always read-only.
module tiny5_csr_counters #(
  parameter int unsigned TIME_DIV = 16
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [11:0] rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        rd_illegal_o,
  input  logic        wr_en_i,
  input  logic [11:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        retire_i,
  output logic        wr_illegal_o
);

  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_TIME     = 12'hC01;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_TIMEH    = 12'hC81;
  localparam logic [11:0] A_INSTRETH = 12'hC82;
  localparam logic [15:0] DIV_LAST   = 16'(TIME_DIV - 1);

  logic [63:0] cycle_q, cycle_d;
  logic [63:0] time_q, time_d;
  logic [63:0] instret_q, instret_d;
  logic [15:0] div_q, div_d;
  logic        wr_illegal_q, wr_illegal_d;

  logic wr_cyc_lo, wr_cyc_hi, wr_ins_lo, wr_ins_hi, wr_legal;

  always_comb begin
    rd_data_o    = 32'd0;
    rd_illegal_o = 1'b0;
    case (rd_addr_i)
      A_CYCLE:    rd_data_o = cycle_q[31:0];
      A_TIME:     rd_data_o = time_q[31:0];
      A_INSTRET:  rd_data_o = instret_q[31:0];
      A_CYCLEH:   rd_data_o = cycle_q[63:32];
      A_TIMEH:    rd_data_o = time_q[63:32];
      A_INSTRETH: rd_data_o = instret_q[63:32];
      default:    rd_illegal_o = 1'b1;
    endcase
  end

`ifdef TINY5_CSR_COUNTER_WR_EN
  assign wr_cyc_lo = wr_en_i && (wr_addr_i == A_CYCLE);
  assign wr_cyc_hi = wr_en_i && (wr_addr_i == A_CYCLEH);
  assign wr_ins_lo = wr_en_i && (wr_addr_i == A_INSTRET);
  assign wr_ins_hi = wr_en_i && (wr_addr_i == A_INSTRETH);
`else
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data_i;
  assign wr_cyc_lo = 1'b0;
  assign wr_cyc_hi = 1'b0;
  assign wr_ins_lo = 1'b0;
  assign wr_ins_hi = 1'b0;
`endif
  assign wr_legal = wr_cyc_lo | wr_cyc_hi | wr_ins_lo | wr_ins_hi;

  // A write replaces one half and blocks that counter's increment, so no carry leaks across.
  always_comb begin
    cycle_d = cycle_q + 64'd1;
    if (wr_cyc_lo)      cycle_d = {cycle_q[63:32], wr_data_i};
    else if (wr_cyc_hi) cycle_d = {wr_data_i, cycle_q[31:0]};

    instret_d = instret_q + {63'd0, retire_i};
    if (wr_ins_lo)      instret_d = {instret_q[63:32], wr_data_i};
    else if (wr_ins_hi) instret_d = {wr_data_i, instret_q[31:0]};

    div_d  = (div_q == DIV_LAST) ? 16'd0 : div_q + 16'd1;
    time_d = time_q + {63'd0, (div_q == DIV_LAST)};

    wr_illegal_d = wr_en_i && !wr_legal;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cycle_q      <= 64'd0;
      time_q       <= 64'd0;
      instret_q    <= 64'd0;
      div_q        <= 16'd0;
      wr_illegal_q <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      time_q       <= time_d;
      instret_q    <= instret_d;
      div_q        <= div_d;
      wr_illegal_q <= wr_illegal_d;
    end
  end

  assign wr_illegal_o = wr_illegal_q;

endmodule

// File: tb/tb_tiny5_csr_counters.sv
// Randomized bench for tiny5_csr_counters against a counts-since-reset reference model.
module tb_tiny5_csr_counters;

  localparam int unsigned TDIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] rd_addr = 12'hC00;
  logic [31:0] rd_data;
  logic        rd_illegal;
  logic        wr_en = 1'b0;
  logic [11:0] wr_addr = 12'h000;
  logic [31:0] wr_data = 32'd0;
  logic        retire = 1'b0;
  logic        wr_illegal;
  logic [11:0] rd_addr1 = 12'hC01;
  logic [31:0] rd_data1;
  logic        rd_illegal1;
  logic        wr_illegal1;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since release, plus cycle/instret as whole 64-bit values.
  longint unsigned n_edges, m_cycle, m_instret;
  logic            m_wr_ill;

  tiny5_csr_counters #(.TIME_DIV(TDIV)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_illegal_o(rd_illegal), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .retire_i(retire), .wr_illegal_o(wr_illegal)
  );

  tiny5_csr_counters #(.TIME_DIV(1)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .rd_addr_i(rd_addr1), .rd_data_o(rd_data1),
    .rd_illegal_o(rd_illegal1), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .retire_i(retire), .wr_illegal_o(wr_illegal1)
  );

  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit writable(input logic [11:0] a);
`ifdef TINY5_CSR_COUNTER_WR_EN
    return (a == 12'hC00) || (a == 12'hC80) || (a == 12'hC02) || (a == 12'hC82);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    longint unsigned t;
    t = n_edges / TDIV;
    case (a)
      12'hC00: return m_cycle[31:0];
      12'hC80: return m_cycle[63:32];
      12'hC01: return t[31:0];
      12'hC81: return t[63:32];
      12'hC02: return m_instret[31:0];
      12'hC82: return m_instret[63:32];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_counter(input logic [11:0] a);
    return (a == 12'hC00) || (a == 12'hC01) || (a == 12'hC02) ||
           (a == 12'hC80) || (a == 12'hC81) || (a == 12'hC82);
  endfunction

  function automatic longint unsigned put_half(input longint unsigned v, input logic [11:0] a,
                                               input logic [31:0] d);
    longint unsigned r;
    r = v;
    if (a[7]) r[63:32] = d;
    else      r[31:0]  = d;
    return r;
  endfunction

  task automatic model_reset();
    n_edges = 0; m_cycle = 0; m_instret = 0; m_wr_ill = 1'b0;
  endtask

  task automatic model_edge();
    n_edges++;
    if (wr_en && writable(wr_addr) && wr_addr[1:0] == 2'd0) m_cycle = put_half(m_cycle, wr_addr, wr_data);
    else m_cycle = m_cycle + 1;
    if (wr_en && writable(wr_addr) && wr_addr[1:0] == 2'd2) m_instret = put_half(m_instret, wr_addr, wr_data);
    else if (retire) m_instret = m_instret + 1;
    m_wr_ill = wr_en && !writable(wr_addr);
  endtask

  task automatic check_all();
    logic [11:0] addrs [6];
    addrs = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};
    foreach (addrs[i]) begin
      rd_addr = addrs[i];
      #1;
      checks++;
      if (rd_data !== model_read(addrs[i]) || rd_illegal !== 1'b0) begin
        errors++;
        $display("FAIL read_%h: got %h ill=%b, want %h ill=0", addrs[i], rd_data, rd_illegal,
                 model_read(addrs[i]));
      end
    end
    checks++;
    if (wr_illegal !== m_wr_ill) begin
      errors++;
      $display("FAIL wr_illegal: got %b want %b (edge %0d)", wr_illegal, m_wr_ill, n_edges);
    end
    checks++;
    if (rd_data1 !== n_edges[31:0]) begin
      errors++;
      $display("FAIL time_div1: got %0d want %0d", rd_data1, n_edges[31:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    wr_en = 1'b0; retire = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    logic [11:0] addrs [6];
    addrs = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};
    foreach (addrs[i]) begin
      rd_addr = addrs[i];
      #1;
      checks++;
      if (rd_data !== 32'd0) begin
        errors++;
        $display("FAIL %s_%h: got %h want 0", tag, addrs[i], rd_data);
      end
    end
    checks++;
    if (wr_illegal !== 1'b0) begin
      errors++;
      $display("FAIL %s_wr_illegal: got %b want 0", tag, wr_illegal);
    end
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check_zero("reset_hold");
    end
    reset_n = 1'b1;
  endtask

  task automatic test_count();
    test_reset();
    repeat (10) tick();
    rd_addr = 12'hC00; #1;
    checks++;
    if (rd_data !== 32'd10) begin errors++; $display("FAIL count10: got %0d want 10", rd_data); end
    rd_addr = 12'hC80; #1;
    checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL count_hi: got %0d want 0", rd_data); end
    rd_addr = 12'h123; #1;
    checks++;
    if (rd_data !== 32'd0 || rd_illegal !== 1'b1) begin
      errors++; $display("FAIL bad_read: got %h ill=%b want 0 ill=1", rd_data, rd_illegal);
    end
  endtask

  task automatic test_instret_time();
    bit pat [12];
    pat = '{1,0,0,1,0,1,0,0,1,0,1,0};
    test_reset();
    foreach (pat[i]) begin
      retire = pat[i];
      tick();
    end
    idle();
    rd_addr = 12'hC02; #1;
    checks++;
    if (rd_data !== 32'd5) begin errors++; $display("FAIL instret5: got %0d want 5", rd_data); end
    rd_addr = 12'hC01; #1;
    checks++;
    if (rd_data !== 32'd3) begin errors++; $display("FAIL time3: got %0d want 3", rd_data); end
  endtask

  task automatic test_illegal_write();
    test_reset();
    repeat (3) tick();
    wr_en = 1'b1; wr_addr = 12'hC00; wr_data = 32'h55;
    tick();
    idle();
    tick();
    wr_en = 1'b1; wr_addr = 12'hC01; wr_data = 32'h77;
    tick();
    wr_addr = 12'hABC;
    tick();
    idle();
    tick();
  endtask

  task automatic test_carry();
    test_reset();
    repeat (2) tick();
    wr_en = 1'b1; wr_addr = 12'hC00; wr_data = 32'hFFFF_FFFE;
    tick();
    idle();
    repeat (3) tick();
    wr_en = 1'b1; wr_addr = 12'hC82; wr_data = 32'h0000_0007; retire = 1'b1;
    tick();
    wr_addr = 12'hC02; wr_data = 32'd100;
    tick();
    wr_addr = 12'hC02; wr_data = 32'hFFFF_FFFF; retire = 1'b0;
    tick();
    wr_en = 1'b0; retire = 1'b1;
    repeat (2) tick();
    idle();
  endtask

  task automatic test_random();
    logic [11:0] pool [8];
    test_reset();
    for (int i = 0; i < 400; i++) begin
      pool = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82, 12'h123, 12'(($urandom))};
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = pool[$urandom_range(0, 7)];
      wr_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      retire  = $urandom_range(0, 1) == 1;
      tick();
      rd_addr = pool[$urandom_range(0, 7)];
      #1;
      checks++;
      if (rd_data !== model_read(rd_addr) || rd_illegal !== !is_counter(rd_addr)) begin
        errors++;
        $display("FAIL rand_read_%h: got %h ill=%b want %h ill=%b", rd_addr, rd_data, rd_illegal,
                 model_read(rd_addr), !is_counter(rd_addr));
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    test_reset();
    while (n_edges < 36) tick();
    wr_en = 1'b1; wr_addr = 12'hC01; wr_data = 32'h1;
    tick();
    idle();
    checks++;
    if (wr_illegal !== 1'b1) begin errors++; $display("FAIL pending_flag: got %b want 1", wr_illegal); end
    reset_n = 1'b0;
    model_reset();
    #1;
    check_zero("mid_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_instret_time();
    test_illegal_write();
    test_carry();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
